// File: rtl/pipe_exec_pkg.sv
// Shared definitions for the pipe_exec_core back end: ALU op codes and the
// EX-stage operand-forwarding select.
package pipe_exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    FWD_DR  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // MEM beats WB when both stages hold the same destination.
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_DR;
  endfunction

endpackage

// File: rtl/pipe_exec_core_if.sv
// Decoded micro-op handshake between the fetch/decode front end (master)
// and the execution back end (slave).
interface pipe_exec_core_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RIDX = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [RIDX-1:0] in_rs1;
  logic [RIDX-1:0] in_rs2;
  logic [RIDX-1:0] in_rd;
  logic [XLEN-1:0] in_imm;
  logic [3:0]      in_alu_op;
  logic            in_use_imm;
  logic            in_mem_read;
  logic            in_mem_write;
  logic            in_reg_write;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_alu_op,
           in_use_imm, in_mem_read, in_mem_write, in_reg_write,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_alu_op,
           in_use_imm, in_mem_read, in_mem_write, in_reg_write,
    output in_ready
  );
endinterface

// File: rtl/pipe_exec_core_alu.sv
// Combinational XLEN-wide integer ALU; unknown op codes yield zero.
module pipe_alu
  import pipe_exec_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/pipe_exec_core.sv
// 4-stage in-order execution back end (DR, EX, MEM, WB) with EX forwarding,
// a one-cycle load-use stall and a synchronous-read data-memory port.
module pipe_exec_core
  import pipe_exec_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned RIDX  = $clog2(NREGS),
  parameter int unsigned ADDRW = 64
) (
  input  logic              clk,
  input  logic              rst,
  pipe_exec_core_if.slave   up,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDRW-1:0]  dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [RIDX-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  input  logic [RIDX-1:0]   dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [31:0]       stall_cnt
);

  logic [XLEN-1:0] regs [NREGS];

  // EX stage registers
  logic            ex_valid, ex_use_imm, ex_mr, ex_mw, ex_rw;
  logic [RIDX-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_a, ex_b, ex_imm;
  logic [3:0]      ex_op;

  // MEM stage registers
  logic            mem_valid, mem_mr, mem_mw, mem_rw;
  logic [RIDX-1:0] mem_rd;
  logic [XLEN-1:0] mem_res, mem_wdata;

  // WB stage registers
  logic            wbs_valid, wbs_mr, wbs_rw;
  logic [RIDX-1:0] wbs_rd;
  logic [XLEN-1:0] wbs_res;

  logic            hazard, stall, accept;
  logic [XLEN-1:0] dr_a, dr_b;
  logic            mem_fwd_ok;
  fwd_sel_e        sel_a, sel_b;
  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic            alu_zero_unused;

  // Load-use: a load in EX cannot forward to the op now in DR.
  assign hazard = ex_valid && ex_mr && (ex_rd != '0) &&
                  ((ex_rd == up.in_rs1) ||
                   ((ex_rd == up.in_rs2) && (!up.in_use_imm || up.in_mem_write)));
  assign stall       = up.in_valid && hazard;
  assign up.in_ready = !stall;
  assign accept      = up.in_valid && !hazard;

  always_comb begin
    dr_a = regs[up.in_rs1];
    dr_b = regs[up.in_rs2];
    if (wb_valid && (wb_rd == up.in_rs1)) dr_a = wb_data;
    if (wb_valid && (wb_rd == up.in_rs2)) dr_b = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_use_imm <= 1'b0;
      ex_mr      <= 1'b0;
      ex_mw      <= 1'b0;
      ex_rw      <= 1'b0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_op      <= '0;
    end else begin
      ex_valid   <= accept;
      ex_use_imm <= up.in_use_imm;
      ex_mr      <= up.in_mem_read;
      ex_mw      <= up.in_mem_write;
      ex_rw      <= up.in_reg_write;
      ex_rs1     <= up.in_rs1;
      ex_rs2     <= up.in_rs2;
      ex_rd      <= up.in_rd;
      ex_a       <= dr_a;
      ex_b       <= dr_b;
      ex_imm     <= up.in_imm;
      ex_op      <= up.in_alu_op;
    end
  end

  // Loads in MEM have no data yet, so only ALU results forward from MEM.
  assign mem_fwd_ok = mem_valid && mem_rw && !mem_mr && (mem_rd != '0);
  assign sel_a = fwd_select(mem_fwd_ok && (mem_rd == ex_rs1), wb_valid && (wb_rd == ex_rs1));
  assign sel_b = fwd_select(mem_fwd_ok && (mem_rd == ex_rs2), wb_valid && (wb_rd == ex_rs2));

  always_comb begin
    unique case (sel_a)
      FWD_MEM: fwd_a = mem_res;
      FWD_WB:  fwd_a = wb_data;
      default: fwd_a = ex_a;
    endcase
    unique case (sel_b)
      FWD_MEM: fwd_b = mem_res;
      FWD_WB:  fwd_b = wb_data;
      default: fwd_b = ex_b;
    endcase
  end

  assign alu_b = ex_use_imm ? ex_imm : fwd_b;

  pipe_alu #(.XLEN(XLEN)) u_alu (
    .op     (ex_op),
    .a      (fwd_a),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_mr    <= 1'b0;
      mem_mw    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_rd    <= '0;
      mem_res   <= '0;
      mem_wdata <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_mr    <= ex_mr;
      mem_mw    <= ex_mw;
      mem_rw    <= ex_rw;
      mem_rd    <= ex_rd;
      mem_res   <= alu_res;
      mem_wdata <= fwd_b;
    end
  end

  // An op flagged both read and write behaves as a load.
  assign dmem_req   = mem_valid && (mem_mr || mem_mw);
  assign dmem_we    = mem_valid && mem_mw && !mem_mr;
  assign dmem_addr  = mem_res[ADDRW-1:0];
  assign dmem_wdata = mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_valid <= 1'b0;
      wbs_mr    <= 1'b0;
      wbs_rw    <= 1'b0;
      wbs_rd    <= '0;
      wbs_res   <= '0;
    end else begin
      wbs_valid <= mem_valid;
      wbs_mr    <= mem_mr;
      wbs_rw    <= mem_rw;
      wbs_rd    <= mem_rd;
      wbs_res   <= mem_res;
    end
  end

  assign wb_valid = wbs_valid && wbs_rw && (wbs_rd != '0);
  assign wb_rd    = wbs_rd;
  assign wb_data  = wbs_mr ? dmem_rdata : wbs_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    dbg_data = regs[dbg_addr];
    if (wb_valid && (wb_rd == dbg_addr)) dbg_data = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule
